// File: rtl/median_window_gen_pkg.sv
// Shared types and defaults for the median-filter column-window generator.
package median_pkg;

    localparam int PIX_W           = 8;
    localparam int IMG_WIDTH_DEF   = 640;
    localparam int IMG_HEIGHT_DEF  = 480;
    localparam int ROW_W           = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME0 = 2'd1,
        PRIME1 = 2'd2,
        STREAM = 2'd3
    } state_e;

endpackage

// File: rtl/median_window_gen_if.sv
// Pixel-in / column-triple-out stream bundle; slave is the generator side.
interface median_window_gen_if;
    import median_pkg::*;

    logic [PIX_W-1:0] in_pixel;
    logic             in_valid;
    logic             in_sof;
    logic             in_eol;
    logic [PIX_W-1:0] pixel_top;
    logic [PIX_W-1:0] pixel_mid;
    logic [PIX_W-1:0] pixel_bot;
    logic             out_valid;
    logic             out_sof;
    logic             out_eol;
    logic             line_err;

    modport slave (
        input  in_pixel, in_valid, in_sof, in_eol,
        output pixel_top, pixel_mid, pixel_bot, out_valid, out_sof, out_eol, line_err
    );

    modport master (
        output in_pixel, in_valid, in_sof, in_eol,
        input  pixel_top, pixel_mid, pixel_bot, out_valid, out_sof, out_eol, line_err
    );

endinterface

// File: rtl/median_window_gen_line_buffer_ram.sv
// Single-clock simple dual-port line RAM, read-first, registered read data.
module line_buffer_ram #(
    parameter int DEPTH  = 640,
    parameter int ADDR_W = 10,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DW-1:0]     rd_data_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DW-1:0]     wr_data_i
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
    end

    // Output register reset only; the array itself is never cleared.
    always_ff @(posedge clk) begin
        if (!rst_n)       rd_data_q <= '0;
        else if (rd_en_i) rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/median_window_gen.sv
// Line-buffers the pixel stream and emits the vertical (y-2, y-1, y) triple per pixel.
module median_window_gen
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = $clog2(IMG_WIDTH)
) (
    input  logic                clk_100M,
    input  logic                rst_n,
    median_window_gen_if.slave  s
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  col_q, col_d, eff_col, wr1_addr_q;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               acc, eol, last_col;
    logic               wr1_en_q;
    logic               ovld_q, ovld_d, osof_q, osof_d, oeol_q, oeol_d, lerr_q, lerr_d;
    logic [PIX_W-1:0]   bot_q, lb0_rd, lb1_rd;

    assign last_col = (col_q == ADDR_W'(IMG_WIDTH - 1));

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        eff_col = col_q;
        acc     = 1'b0;
        eol     = 1'b0;
        ovld_d  = 1'b0;
        osof_d  = 1'b0;
        oeol_d  = 1'b0;
        lerr_d  = 1'b0;
        if (s.in_valid) begin
            if (s.in_sof) begin
                // A new frame aborts whatever was in flight; in_eol on this pixel is ignored.
                acc     = 1'b1;
                eff_col = '0;
                col_d   = ADDR_W'(1);
                row_d   = '0;
                state_d = PRIME0;
            end else if (state_q != IDLE) begin
                acc    = 1'b1;
                eol    = s.in_eol || last_col;
                lerr_d = s.in_eol != last_col;
                ovld_d = (state_q == STREAM);
                osof_d = ovld_d && (row_q == ROW_W'(2)) && (col_q == '0);
                oeol_d = ovld_d && eol;
                if (eol) begin
                    col_d = '0;
                    row_d = row_q + ROW_W'(1);
                    case (state_q)
                        PRIME0:  state_d = PRIME1;
                        PRIME1:  state_d = STREAM;
                        STREAM: begin
                            if (row_q == ROW_W'(IMG_HEIGHT - 1)) begin
                                state_d = IDLE;
                                row_d   = '0;
                            end
                        end
                        default: state_d = IDLE;
                    endcase
                end else begin
                    col_d = col_q + ADDR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_100M) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            wr1_en_q   <= 1'b0;
            wr1_addr_q <= '0;
            bot_q      <= '0;
            ovld_q     <= 1'b0;
            osof_q     <= 1'b0;
            oeol_q     <= 1'b0;
            lerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            wr1_en_q   <= acc;
            if (acc) begin
                wr1_addr_q <= eff_col;
                bot_q      <= s.in_pixel;
            end
            ovld_q     <= ovld_d;
            osof_q     <= osof_d;
            oeol_q     <= oeol_d;
            lerr_q     <= lerr_d;
        end
    end

    // lb0 holds row y-1; its read-first output is the old value that lb1 inherits next cycle.
    line_buffer_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W), .DW(PIX_W)) u_lb0 (
        .clk       (clk_100M),
        .rst_n     (rst_n),
        .rd_en_i   (acc),
        .rd_addr_i (eff_col),
        .rd_data_o (lb0_rd),
        .wr_en_i   (acc),
        .wr_addr_i (eff_col),
        .wr_data_i (s.in_pixel)
    );

    line_buffer_ram #(.DEPTH(IMG_WIDTH), .ADDR_W(ADDR_W), .DW(PIX_W)) u_lb1 (
        .clk       (clk_100M),
        .rst_n     (rst_n),
        .rd_en_i   (acc),
        .rd_addr_i (eff_col),
        .rd_data_o (lb1_rd),
        .wr_en_i   (wr1_en_q),
        .wr_addr_i (wr1_addr_q),
        .wr_data_i (lb0_rd)
    );

    assign s.pixel_top = lb1_rd;
    assign s.pixel_mid = lb0_rd;
    assign s.pixel_bot = bot_q;
    assign s.out_valid = ovld_q;
    assign s.out_sof   = osof_q;
    assign s.out_eol   = oeol_q;
    assign s.line_err  = lerr_q;

endmodule
